// File: rtl/timer_ctrl_master_if.sv
// Avalon-style slave bus between timer_ctrl_master and the timer peripheral.
// Read data is registered in the peripheral and arrives one cycle after the address.
interface timer_ctrl_master_if;
    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_chipselect,
        output avm_write_n,
        output avm_writedata,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_chipselect,
        input  avm_write_n,
        input  avm_writedata,
        output avm_readdata
    );
endinterface

// File: rtl/timer_ctrl_master.sv
// Programs, services and stops a memory-mapped timer peripheral.
// Define TIMER_CTRL_SNAPSHOT_EN to read back the 32-bit counter snapshot after each timeout.
module timer_ctrl_master (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [31:0]         period_value,
    input  logic                continuous,
    input  logic                irq_in,
    timer_ctrl_master_if.master avm,
    output logic                busy,
    output logic                done,
    output logic [15:0]         tick_count,
    output logic [31:0]         snapshot,
    output logic                snapshot_valid
);

    localparam logic [2:0]  ADDR_STATUS = 3'd0;
    localparam logic [2:0]  ADDR_CTRL   = 3'd1;
    localparam logic [2:0]  ADDR_PER_L  = 3'd2;
    localparam logic [2:0]  ADDR_PER_H  = 3'd3;
    localparam logic [2:0]  ADDR_SNAP_L = 3'd4;
    localparam logic [2:0]  ADDR_SNAP_H = 3'd5;
    localparam logic [15:0] CTRL_STOP   = 16'h0008;

`ifdef TIMER_CTRL_SNAPSHOT_EN
    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        WR_PL      = 4'd1,
        WR_PH      = 4'd2,
        WR_CTRL    = 4'd3,
        WAIT_IRQ   = 4'd4,
        CLR_STATUS = 4'd5,
        SNAP_WR    = 4'd6,
        RD_L       = 4'd7,
        CAP_L      = 4'd8,
        RD_H       = 4'd9,
        CAP_H      = 4'd10,
        STOP       = 4'd11
    } state_t;
`else
    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        WR_PL      = 4'd1,
        WR_PH      = 4'd2,
        WR_CTRL    = 4'd3,
        WAIT_IRQ   = 4'd4,
        CLR_STATUS = 4'd5,
        STOP       = 4'd11
    } state_t;
`endif

    state_t      state_reg;
    state_t      state_next;
    state_t      post_state;
    logic        stop_pending_reg;
    logic        stop_pending_next;
    logic        stop_any;
    logic        start_accept;
    logic [31:0] period_reg;
    logic        continuous_reg;
    logic [15:0] tick_count_reg;
    logic        done_reg;

    logic [2:0]  bus_address;
    logic        bus_chipselect;
    logic        bus_write_n;
    logic [15:0] bus_writedata;

    // A stop seen in the current cycle redirects the very next transition.
    assign stop_any     = stop | stop_pending_reg;
    assign start_accept = (state_reg == IDLE) && start && !stop;
    assign post_state   = continuous_reg ? WAIT_IRQ : IDLE;

    always_comb begin
        state_next     = state_reg;
        bus_address    = ADDR_STATUS;
        bus_chipselect = 1'b0;
        bus_write_n    = 1'b1;
        bus_writedata  = 16'h0000;
        case (state_reg)
            IDLE: begin
                if (stop) begin
                    state_next = STOP;
                end else if (start) begin
                    state_next = WR_PL;
                end
            end
            WR_PL: begin
                bus_address    = ADDR_PER_L;
                bus_chipselect = 1'b1;
                bus_write_n    = 1'b0;
                bus_writedata  = period_reg[15:0];
                state_next     = stop_any ? STOP : WR_PH;
            end
            WR_PH: begin
                bus_address    = ADDR_PER_H;
                bus_chipselect = 1'b1;
                bus_write_n    = 1'b0;
                bus_writedata  = period_reg[31:16];
                state_next     = stop_any ? STOP : WR_CTRL;
            end
            WR_CTRL: begin
                bus_address    = ADDR_CTRL;
                bus_chipselect = 1'b1;
                bus_write_n    = 1'b0;
                bus_writedata  = {12'h000, 1'b0, 1'b1, continuous_reg, 1'b1};
                state_next     = stop_any ? STOP : WAIT_IRQ;
            end
            WAIT_IRQ: begin
                if (stop_any) begin
                    state_next = STOP;
                end else if (irq_in) begin
                    state_next = CLR_STATUS;
                end
            end
            CLR_STATUS: begin
                bus_address    = ADDR_STATUS;
                bus_chipselect = 1'b1;
                bus_write_n    = 1'b0;
                bus_writedata  = 16'h0000;
`ifdef TIMER_CTRL_SNAPSHOT_EN
                state_next     = stop_any ? STOP : SNAP_WR;
`else
                state_next     = stop_any ? STOP : post_state;
`endif
            end
`ifdef TIMER_CTRL_SNAPSHOT_EN
            SNAP_WR: begin
                // Writing snap_l latches the running counter into snap_l/snap_h.
                bus_address    = ADDR_SNAP_L;
                bus_chipselect = 1'b1;
                bus_write_n    = 1'b0;
                bus_writedata  = 16'h0000;
                state_next     = stop_any ? STOP : RD_L;
            end
            RD_L: begin
                bus_address    = ADDR_SNAP_L;
                bus_chipselect = 1'b1;
                state_next     = stop_any ? STOP : CAP_L;
            end
            CAP_L: begin
                state_next = stop_any ? STOP : RD_H;
            end
            RD_H: begin
                bus_address    = ADDR_SNAP_H;
                bus_chipselect = 1'b1;
                state_next     = stop_any ? STOP : CAP_H;
            end
            CAP_H: begin
                state_next = stop_any ? STOP : post_state;
            end
`endif
            STOP: begin
                bus_address    = ADDR_CTRL;
                bus_chipselect = 1'b1;
                bus_write_n    = 1'b0;
                bus_writedata  = CTRL_STOP;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        stop_pending_next = stop_pending_reg;
        if (state_reg == STOP) begin
            stop_pending_next = 1'b0;
        end else if (stop && (state_reg != IDLE)) begin
            stop_pending_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            stop_pending_reg <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            stop_pending_reg <= stop_pending_next;
            done_reg         <= (state_reg != IDLE) && (state_next == IDLE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_reg     <= 32'h0000_0000;
            continuous_reg <= 1'b0;
            tick_count_reg <= 16'h0000;
        end else begin
            if (start_accept) begin
                period_reg     <= period_value;
                continuous_reg <= continuous;
                tick_count_reg <= 16'h0000;
            end else if (state_reg == CLR_STATUS) begin
                tick_count_reg <= tick_count_reg + 16'd1;
            end
        end
    end

`ifdef TIMER_CTRL_SNAPSHOT_EN
    logic [31:0] snapshot_reg;
    logic        snapshot_valid_reg;
    logic [1:0]  cap_en;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_cap
        assign cap_en[gi] = (state_reg == ((gi == 0) ? CAP_L : CAP_H));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snapshot_reg       <= 32'h0000_0000;
            snapshot_valid_reg <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (cap_en[i]) begin
                    snapshot_reg[i*16 +: 16] <= avm.avm_readdata;
                end
            end
            snapshot_valid_reg <= cap_en[1];
        end
    end

    assign snapshot       = snapshot_reg;
    assign snapshot_valid = snapshot_valid_reg;
`else
    logic unused_readdata;
    assign unused_readdata = ^avm.avm_readdata;
    assign snapshot        = 32'h0000_0000;
    assign snapshot_valid  = 1'b0;
`endif

    assign avm.avm_address    = bus_address;
    assign avm.avm_chipselect = bus_chipselect;
    assign avm.avm_write_n    = bus_write_n;
    assign avm.avm_writedata  = bus_writedata;

    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;
    assign tick_count = tick_count_reg;

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Scoreboard bench for timer_ctrl_master: stimulus queues expected bus cycles/pulses,
// a negedge monitor pops and compares whenever the DUT drives the bus, snapshot_valid or done.
module tb_timer_ctrl_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] period_value = 32'h0;
    logic        continuous = 1'b0;
    logic        irq_in = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] tick_count;
    logic [31:0] snapshot;
    logic        snapshot_valid;

    timer_ctrl_master_if bus_if ();

    timer_ctrl_master dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .period_value   (period_value),
        .continuous     (continuous),
        .irq_in         (irq_in),
        .avm            (bus_if),
        .busy           (busy),
        .done           (done),
        .tick_count     (tick_count),
        .snapshot       (snapshot),
        .snapshot_valid (snapshot_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral model: registered read data for the snapshot words.
    logic [31:0] snap_val = 32'h0000_1234;
    always @(posedge clk) begin
        if (bus_if.avm_chipselect && bus_if.avm_write_n) begin
            case (bus_if.avm_address)
                3'd4:    bus_if.avm_readdata <= snap_val[15:0];
                3'd5:    bus_if.avm_readdata <= snap_val[31:16];
                default: bus_if.avm_readdata <= 16'h0000;
            endcase
        end else begin
            bus_if.avm_readdata <= 16'h0000;
        end
    end

    typedef enum {EV_BUS, EV_SNAP, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        int          cycle;
        bit          we;
        logic [2:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int failures = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic void push(ev_kind_t k, int c, bit we, logic [2:0] a, logic [31:0] d);
        exp_t e;
        e.kind  = k;
        e.cycle = c;
        e.we    = we;
        e.addr  = a;
        e.data  = d;
        sb_q.push_back(e);
    endfunction

    function automatic void observe(ev_kind_t k, bit we, logic [2:0] a, logic [31:0] d);
        exp_t e;
        bit   bad;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s: cycle=%0d we=%0d addr=%0d data=0x%08h expected nothing",
                     k.name(), cyc, we, a, d);
            return;
        end
        e = sb_q.pop_front();
        bad = (e.kind != k) || (e.cycle != cyc);
        if (k == EV_BUS)
            bad = bad || (e.we != we) || (e.addr != a) || (we && (e.data[15:0] != d[15:0]));
        else
            bad = bad || (e.data != d);
        if (bad) begin
            failures++;
            $display("FAIL %s: got cycle=%0d we=%0d addr=%0d data=0x%08h expected %s cycle=%0d we=%0d addr=%0d data=0x%08h",
                     k.name(), cyc, we, a, d, e.kind.name(), e.cycle, e.we, e.addr, e.data);
        end
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (bus_if.avm_chipselect)
                observe(EV_BUS, !bus_if.avm_write_n, bus_if.avm_address, {16'h0, bus_if.avm_writedata});
            if (snapshot_valid)
                observe(EV_SNAP, 1'b0, 3'd0, snapshot);
            if (done)
                observe(EV_DONE, 1'b0, 3'd0, {16'h0, tick_count});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_values();
        @(negedge clk);
        check("rst_address", {29'h0, bus_if.avm_address}, 32'h0);
        check("rst_chipselect", {31'h0, bus_if.avm_chipselect}, 32'h0);
        check("rst_write_n", {31'h0, bus_if.avm_write_n}, 32'h1);
        check("rst_writedata", {16'h0, bus_if.avm_writedata}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_tick_count", {16'h0, tick_count}, 32'h0);
        check("rst_snapshot", snapshot, 32'h0);
        check("rst_snapshot_valid", {31'h0, snapshot_valid}, 32'h0);
    endtask

    // Issues start in the current cycle; returns one cycle later (first write cycle).
    task automatic do_start(input logic [31:0] p, input bit cont, input bit issue_ctrl);
        int c;
        c = cyc;
        period_value = p;
        continuous   = cont;
        start        = 1'b1;
        push(EV_BUS, c + 1, 1'b1, 3'd2, {16'h0, p[15:0]});
        push(EV_BUS, c + 2, 1'b1, 3'd3, {16'h0, p[31:16]});
        if (issue_ctrl)
            push(EV_BUS, c + 3, 1'b1, 3'd1, {28'h0, 1'b0, 1'b1, cont, 1'b1});
        step(1);
        start        = 1'b0;
        period_value = 32'h0;
        continuous   = 1'b0;
    endtask

    // Raises irq in the current (WAIT_IRQ) cycle; returns in the post-service cycle.
    task automatic service(input bit cont, input logic [15:0] exp_tick);
        int t;
        int post;
        t = cyc;
        irq_in = 1'b1;
        push(EV_BUS, t + 1, 1'b1, 3'd0, 32'h0);
`ifdef TIMER_CTRL_SNAPSHOT_EN
        push(EV_BUS, t + 2, 1'b1, 3'd4, 32'h0);
        push(EV_BUS, t + 3, 1'b0, 3'd4, 32'h0);
        push(EV_BUS, t + 5, 1'b0, 3'd5, 32'h0);
        post = t + 7;
        push(EV_SNAP, post, 1'b0, 3'd0, snap_val);
`else
        post = t + 2;
`endif
        if (!cont)
            push(EV_DONE, post, 1'b0, 3'd0, {16'h0, exp_tick});
        step(1);
        irq_in = 1'b0;
        while (cyc < post)
            step(1);
    endtask

    task automatic stop_pulse(input bit with_start, input logic [15:0] exp_tick);
        int s;
        s = cyc;
        stop = 1'b1;
        if (with_start) begin
            start        = 1'b1;
            period_value = 32'h0000_0055;
        end
        push(EV_BUS, s + 1, 1'b1, 3'd1, 32'h0000_0008);
        push(EV_DONE, s + 2, 1'b0, 3'd0, {16'h0, exp_tick});
        step(1);
        stop         = 1'b0;
        start        = 1'b0;
        period_value = 32'h0;
        step(1);
    endtask

    initial begin
        int c;
        // Reset state
        step(2);
        check_reset_values();
        step(1);
        reset = 1'b0;
        step(1);
        @(negedge clk);
        check("idle_busy", {31'h0, busy}, 32'h0);

        // One-shot programming and a single timeout
        step(1);
        snap_val = 32'h0000_1234;
        do_start(32'h0001_86A0, 1'b0, 1'b1);
        @(negedge clk);
        check("oneshot_busy", {31'h0, busy}, 32'h1);
        step(3);
        service(1'b0, 16'd1);
        @(negedge clk);
        check("oneshot_idle_busy", {31'h0, busy}, 32'h0);
        check("oneshot_tick", {16'h0, tick_count}, 32'h1);
`ifdef TIMER_CTRL_SNAPSHOT_EN
        check("oneshot_snapshot", snapshot, 32'h0000_1234);
`else
        check("oneshot_snapshot", snapshot, 32'h0);
`endif
        step(2);

        // Continuous mode, period 0, stray irq before WAIT_IRQ, three timeouts
        snap_val = 32'h00A5_5A00;
        do_start(32'h0000_0000, 1'b1, 1'b1);
        step(1);
        irq_in = 1'b1;
        step(1);
        irq_in = 1'b0;
        step(3);
        service(1'b1, 16'd0);
        step(2);
        service(1'b1, 16'd0);
        service(1'b1, 16'd0);
        @(negedge clk);
        check("cont_tick", {16'h0, tick_count}, 32'h3);
        check("cont_busy", {31'h0, busy}, 32'h1);
        step(1);
        // start while busy must be ignored
        start        = 1'b1;
        period_value = 32'hFFFF_FFFF;
        step(1);
        start        = 1'b0;
        period_value = 32'h0;
        step(2);
        @(negedge clk);
        check("busy_start_tick", {16'h0, tick_count}, 32'h3);
        step(1);
        stop_pulse(1'b0, 16'd3);
        @(negedge clk);
        check("stopped_busy", {31'h0, busy}, 32'h0);
        step(2);

        // start+stop together in IDLE, then lone stop in IDLE
        stop_pulse(1'b1, 16'd3);
        step(2);
        stop_pulse(1'b0, 16'd3);
        step(2);

        // stop during WR_PH: no control write, STOP write follows
        c = cyc;
        do_start(32'hCAFE_0042, 1'b0, 1'b0);
        step(1);
        stop = 1'b1;
        push(EV_BUS, c + 3, 1'b1, 3'd1, 32'h0000_0008);
        push(EV_DONE, c + 4, 1'b0, 3'd0, 32'h0);
        step(1);
        stop = 1'b0;
        step(3);

        // Reset mid-service, then a fresh run
        snap_val = 32'hDEAD_BEEF;
        do_start(32'h0000_0010, 1'b0, 1'b1);
        step(3);
`ifdef TIMER_CTRL_SNAPSHOT_EN
        c = cyc;
        irq_in = 1'b1;
        push(EV_BUS, c + 1, 1'b1, 3'd0, 32'h0);
        push(EV_BUS, c + 2, 1'b1, 3'd4, 32'h0);
        push(EV_BUS, c + 3, 1'b0, 3'd4, 32'h0);
        step(1);
        irq_in = 1'b0;
        step(3);
`else
        step(1);
`endif
        reset = 1'b1;
        check_reset_values();
        step(1);
        reset = 1'b0;
        step(1);
        do_start(32'h0002_0003, 1'b0, 1'b1);
        step(3);
        service(1'b0, 16'd1);
        step(3);

        check("scoreboard_empty", sb_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_ctrl_master.md
TIMER_CTRL_MASTER -- requirements
Module: timer_ctrl_master

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 reset  input  1  one clock; reset is asynchronous and active-high.
REQ-003 start  input  1  one-cycle pulse: program and run the timer peripheral.
REQ-004 stop  input  1  one-cycle pulse: stop the timer peripheral and return to idle.
REQ-005 period_value  input  32  timer period, sampled on an accepted start.
REQ-006 continuous  input  1  1 = periodic mode; 0 = one-shot; sampled on an accepted start.
REQ-007 irq_in  input  1  interrupt from the timer peripheral.
REQ-008 avm_readdata  input  16  peripheral read data, registered, 1-cycle latency after address is presented.
REQ-009 avm_address  output  3  peripheral word address: 0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h.
REQ-010 avm_chipselect  output  1  bus access active.
REQ-011 avm_write_n  output  1  0 = write in this cycle.
REQ-012 avm_writedata  output  16  write data.
REQ-013 busy  output  1  1 whenever FSM is not IDLE.
REQ-014 done  output  1  one-cycle pulse on return to IDLE.
REQ-015 tick_count  output  16  number of serviced timeouts since last accepted start; wraps 0xFFFF->0.
REQ-016 snapshot  output  32  last captured counter snapshot.
REQ-017 snapshot_valid  output  1  one-cycle pulse when snapshot updates.

Function
REQ-018 States SHALL be: IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, CLR_STATUS, SNAP_WR, RD_L, CAP_L, RD_H, CAP_H, STOP.
REQ-019 Each write state SHALL last exactly one cycle with chipselect=1 and write_n=0; in all other cycles write_n=1.
REQ-020 Write data: WR_PL addr 2, period[15:0]; WR_PH addr 3, period[31:16]; WR_CTRL addr 1, {0,1,continuous,1}; CLR_STATUS addr 0, 0x0000; SNAP_WR addr 4, 0x0000; STOP addr 1, 0x0008.
REQ-021 In IDLE, start SHALL move the FSM to WR_PL, clear tick_count and latch period_value and continuous; start outside IDLE SHALL be ignored.
REQ-022 The write sequence SHALL be WR_PL->WR_PH->WR_CTRL->WAIT_IRQ, one state per cycle.
REQ-023 WAIT_IRQ SHALL idle the bus (chipselect=0) and SHALL go to CLR_STATUS in the cycle after irq_in is sampled high.
REQ-024 CLR_STATUS SHALL increment tick_count by 1 and SHALL go to SNAP_WR (macro defined) or to the post-service decision (macro undefined).
REQ-025 Snapshot read: RD_L drives addr 4 (chipselect=1, write_n=1); CAP_L captures avm_readdata into snapshot[15:0]; RD_H and CAP_H do the same for addr 5 into snapshot[31:16]; snapshot_valid pulses in the cycle after CAP_H.
REQ-026 Post-service decision: if the latched mode is continuous, go to WAIT_IRQ; otherwise go to IDLE and pulse done.
REQ-027 A stop pulse outside IDLE SHALL set stop_pending; the current state completes, then the FSM enters STOP instead of its next state; STOP->IDLE with done pulse; stop_pending clears.
REQ-028 start and stop both high in IDLE: stop wins; FSM goes to STOP.
REQ-029 A lone stop in IDLE SHALL go to STOP, so the peripheral is always halted.
REQ-030 irq_in high on the cycle WAIT_IRQ is entered SHALL be serviced; irq_in in other states SHALL be ignored until WAIT_IRQ.
REQ-031 period_value 0 SHALL be written unmodified.

Reset
REQ-032 While reset is asserted, the FSM SHALL be in IDLE, with avm_address=0, avm_chipselect=0, avm_write_n=1, avm_writedata=0, busy=0, done=0, tick_count=0, snapshot=0, snapshot_valid=0, stop_pending=0.
REQ-033 Reset mid-operation SHALL abort immediately with no bus access; the peripheral is left as last programmed.

Configuration
REQ-034 Macro TIMER_CTRL_SNAPSHOT_EN defined: states SNAP_WR through CAP_H are present and the snapshot and snapshot_valid outputs are live.
REQ-035 Macro TIMER_CTRL_SNAPSHOT_EN undefined: those states are removed, snapshot is tied to 0, snapshot_valid is tied to 0, and CLR_STATUS goes directly to the post-service decision.

Verification
REQ-036 start with period=0x0001_86A0, continuous=0 -> writes (2,0x86A0),(3,0x0001),(1,0x0005) on 3 consecutive cycles; busy=1.
REQ-037 Peripheral model times out, snapshot=0x0000_1234 -> write (0,0x0000); snapshot=0x00001234 with snapshot_valid pulse; tick_count=1; done pulses; IDLE.
REQ-038 continuous=1, 3 timeouts -> control write data 0x0007; tick_count=3; FSM in WAIT_IRQ; done never pulses.
REQ-039 stop pulse during WR_PH -> WR_PH completes, then write (1,0x0008), then IDLE, done=1; WR_CTRL is never issued.
REQ-040 reset asserted in CAP_L -> next cycle all outputs are at REQ-032 values; a new start begins again at WR_PL.
REQ-041 Macro undefined, one-shot timeout -> no access to address 4 or 5; CLR_STATUS is followed by done in the next cycle.
